// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the load extension unit.
//   MODE_W        width of the extension-mode code
//   MODE_*        extension-mode codes
//   mode_is_aligned(mode, off_lo) returns 1 when the access at the given low
//                 offset bits is naturally aligned for that mode
package ext_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_ZEXT1  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LB     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_LBU    = 3'd2;
  localparam logic [MODE_W-1:0] MODE_LH     = 3'd3;
  localparam logic [MODE_W-1:0] MODE_LHU    = 3'd4;
  localparam logic [MODE_W-1:0] MODE_LW     = 3'd5;
  localparam logic [MODE_W-1:0] MODE_LUI    = 3'd6;
  localparam logic [MODE_W-1:0] MODE_SEXT16 = 3'd7;

  // Only halfword and word loads have alignment constraints; the other modes
  // either pick single bytes or ignore the offset altogether.
  function automatic logic mode_is_aligned(input logic [MODE_W-1:0] mode,
                                           input logic [1:0]        off_lo);
    logic ok;
    case (mode)
      MODE_LH, MODE_LHU: ok = ~off_lo[0];
      MODE_LW:           ok = (off_lo == 2'b00);
      default:           ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational lane extraction and zero/sign extension.
//   data_i      raw memory word / SLT result / immediate
//   off_i       byte offset of the access (little-endian lanes)
//   mode_i      extension mode (ext_pkg MODE_*)
//   ext_data_o  extended result, zero when misaligned
//   misalign_o  access is misaligned for its mode
module ext_core
  import ext_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [DATA_W-1:0] ext_data_o,
  output logic              misalign_o
);

  logic [DATA_W-1:0] shifted;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       lane_w;
  logic [31:0]       lui_w;
  logic              aligned;

  // Bring the addressed lane down to bit 0.
  assign shifted = data_i >> {off_i, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = shifted[15:0];
  assign lane_w  = shifted[31:0];
  assign lui_w   = {data_i[15:0], 16'h0000};
  assign aligned = mode_is_aligned(mode_i, off_i[1:0]);

  always_comb begin
    ext_data_o = '0;
    case (mode_i)
      MODE_ZEXT1: ext_data_o[0] = data_i[0];
      MODE_LB: begin
        ext_data_o      = {DATA_W{lane_b[7]}};
        ext_data_o[7:0] = lane_b;
      end
      MODE_LBU:   ext_data_o[7:0] = lane_b;
      MODE_LH: begin
        ext_data_o       = {DATA_W{lane_h[15]}};
        ext_data_o[15:0] = lane_h;
      end
      MODE_LHU:   ext_data_o[15:0] = lane_h;
      MODE_LW: begin
        ext_data_o       = {DATA_W{lane_w[31]}};
        ext_data_o[31:0] = lane_w;
      end
      MODE_LUI: begin
        ext_data_o       = {DATA_W{lui_w[31]}};
        ext_data_o[31:0] = lui_w;
      end
      default: begin
        ext_data_o       = {DATA_W{data_i[15]}};
        ext_data_o[15:0] = data_i[15:0];
      end
    endcase
    if (!aligned) begin
      ext_data_o = '0;
    end
  end

  assign misalign_o = ~aligned;

endmodule

// File: rtl/load_ext_unit.sv
// load_ext_unit: registered extension/alignment unit with a 2-entry
// valid/ready buffer and a saturating misalignment counter.
//   clk, reset           clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready depends only on occupancy
//   in_data/off/mode     raw word, byte offset, extension mode
//   out_valid/out_ready  output handshake, head of the buffer
//   out_data/misalign    registered head entry
//   misalign_cnt         saturating count of accepted misaligned beats
//   cnt_clr              synchronous clear of misalign_cnt (wins over increment)
module load_ext_unit
  import ext_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8),
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_misalign,
  output logic [CNT_W-1:0]  misalign_cnt,
  input  logic              cnt_clr
);

  logic [DATA_W-1:0] core_data;
  logic              core_mis;

  ext_core #(
    .DATA_W(DATA_W),
    .OFF_W (OFF_W)
  ) u_core (
    .data_i    (in_data),
    .off_i     (in_off),
    .mode_i    (in_mode),
    .ext_data_o(core_data),
    .misalign_o(core_mis)
  );

  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              head_mis_q, head_mis_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic              tail_mis_q, tail_mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, emit;

  assign in_ready     = (count_q != 2'd2);
  assign out_valid    = (count_q != 2'd0);
  assign out_data     = head_data_q;
  assign out_misalign = head_mis_q;
  assign misalign_cnt = cnt_q;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_mis_d  = head_mis_q;
    tail_data_d = tail_data_q;
    tail_mis_d  = tail_mis_q;
    if (accept && emit) begin
      // Only reachable at count 1: new beat replaces the head, no bubble.
      head_data_d = core_data;
      head_mis_d  = core_mis;
    end else if (accept) begin
      if (count_q == 2'd0) begin
        head_data_d = core_data;
        head_mis_d  = core_mis;
      end else begin
        tail_data_d = core_data;
        tail_mis_d  = core_mis;
      end
      count_d = count_q + 2'd1;
    end else if (emit) begin
      head_data_d = tail_data_q;
      head_mis_d  = tail_mis_q;
      count_d     = count_q - 2'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && core_mis && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_mis_q  <= 1'b0;
      tail_data_q <= '0;
      tail_mis_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_mis_q  <= head_mis_d;
      tail_data_q <= tail_data_d;
      tail_mis_q  <= tail_mis_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_load_ext_unit.sv
// tb_load_ext_unit: directed self-checking bench. Instance a is the default
// 32-bit unit; instance b is 64-bit with a 2-bit misalignment counter.
module tb_load_ext_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance a: DATA_W=32, CNT_W=8
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [31:0] a_in_data = '0;
  logic [1:0]  a_in_off = '0;
  logic [2:0]  a_in_mode = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [31:0] a_out_data;
  logic        a_out_misalign;
  logic [7:0]  a_cnt;
  logic        a_cnt_clr = 1'b0;

  // Instance b: DATA_W=64, CNT_W=2
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [63:0] b_in_data = '0;
  logic [2:0]  b_in_off = '0;
  logic [2:0]  b_in_mode = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [63:0] b_out_data;
  logic        b_out_misalign;
  logic [1:0]  b_cnt;
  logic        b_cnt_clr = 1'b0;

  load_ext_unit #(.DATA_W(32), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_off(a_in_off), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_misalign(a_out_misalign), .misalign_cnt(a_cnt), .cnt_clr(a_cnt_clr)
  );

  load_ext_unit #(.DATA_W(64), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_off(b_in_off), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_misalign(b_out_misalign), .misalign_cnt(b_cnt), .cnt_clr(b_cnt_clr)
  );

  // One beat into instance a; returns #1 after the accepting edge.
  task automatic push_a(input logic [31:0] d, input logic [1:0] off, input logic [2:0] mode);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_off   = off;
    a_in_mode  = mode;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_cnt !== 8'h0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a: valid=%b data=%h cnt=%h ready=%b, want 0 0 0 1",
               a_out_valid, a_out_data, a_cnt, a_in_ready);
    end
    n_tests++;
    if (b_out_valid !== 1'b0 || b_out_data !== 64'h0 || b_cnt !== 2'h0 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_b: valid=%b data=%h cnt=%h ready=%b, want 0 0 0 1",
               b_out_valid, b_out_data, b_cnt, b_in_ready);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_lb_lbu();
    logic [31:0] exp_lb [4];
    exp_lb[0] = 32'h00000001;
    exp_lb[1] = 32'h0000007F;
    exp_lb[2] = 32'hFFFFFFFF;
    exp_lb[3] = 32'hFFFFFF80;
    for (int k = 0; k < 4; k++) begin
      push_a(32'h80FF7F01, 2'(k), 3'd1);
      n_tests++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp_lb[k] || a_out_misalign !== 1'b0) begin
        n_fail++;
        $display("FAIL lb_off%0d: valid=%b data=%h mis=%b, want 1 %h 0",
                 k, a_out_valid, a_out_data, a_out_misalign, exp_lb[k]);
      end
    end
    push_a(32'h80FF7F01, 2'd3, 3'd2);
    n_tests++;
    if (a_out_data !== 32'h00000080) begin
      n_fail++;
      $display("FAIL lbu_off3: data=%h, want 00000080", a_out_data);
    end
    idle(1);
  endtask

  task automatic test_lh_misalign();
    push_a(32'h80017FFE, 2'd2, 3'd3);
    n_tests++;
    if (a_out_data !== 32'hFFFF8001 || a_out_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL lh_off2: data=%h mis=%b, want FFFF8001 0", a_out_data, a_out_misalign);
    end
    push_a(32'h80017FFE, 2'd0, 3'd4);
    n_tests++;
    if (a_out_data !== 32'h00007FFE) begin
      n_fail++;
      $display("FAIL lhu_off0: data=%h, want 00007FFE", a_out_data);
    end
    idle(1);
    n_tests++;
    if (a_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL cnt_before_mis: cnt=%0d, want 0", a_cnt);
    end
    push_a(32'h80017FFE, 2'd1, 3'd3);
    n_tests++;
    if (a_out_data !== 32'h0 || a_out_misalign !== 1'b1 || a_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL lh_off1_mis: data=%h mis=%b cnt=%0d, want 0 1 1",
               a_out_data, a_out_misalign, a_cnt);
    end
    idle(1);
  endtask

  task automatic test_zext_lui_sext();
    push_a(32'hFFFF8003, 2'd2, 3'd0);
    n_tests++;
    if (a_out_data !== 32'h00000001) begin
      n_fail++;
      $display("FAIL zext1: data=%h, want 00000001", a_out_data);
    end
    push_a(32'hFFFF8003, 2'd1, 3'd6);
    n_tests++;
    if (a_out_data !== 32'h80030000 || a_out_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL lui32: data=%h mis=%b, want 80030000 0", a_out_data, a_out_misalign);
    end
    push_a(32'hFFFF8003, 2'd3, 3'd7);
    n_tests++;
    if (a_out_data !== 32'hFFFF8003 || a_out_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL sext16: data=%h mis=%b, want FFFF8003 0", a_out_data, a_out_misalign);
    end
    idle(1);
    b_in_valid = 1'b1;
    b_in_data  = 64'h00000000FFFF8003;
    b_in_off   = 3'd0;
    b_in_mode  = 3'd6;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    n_tests++;
    if (b_out_valid !== 1'b1 || b_out_data !== 64'hFFFFFFFF80030000) begin
      n_fail++;
      $display("FAIL lui64: valid=%b data=%h, want 1 FFFFFFFF80030000", b_out_valid, b_out_data);
    end
    idle(1);
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_mode   = 3'd5;
    a_in_off    = 2'd0;
    a_in_data   = 32'h11111111;
    @(posedge clk);
    #1;
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_data !== 32'h11111111) begin
      n_fail++;
      $display("FAIL bp_first: ready=%b data=%h, want 1 11111111", a_in_ready, a_out_data);
    end
    a_in_data = 32'h22222222;
    @(posedge clk);
    #1;
    n_tests++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: ready=%b valid=%b, want 0 1", a_in_ready, a_out_valid);
    end
    a_in_data = 32'h33333333;
    @(posedge clk);
    #1;
    n_tests++;
    if (a_in_ready !== 1'b0 || a_out_data !== 32'h11111111) begin
      n_fail++;
      $display("FAIL bp_hold: ready=%b data=%h, want 0 11111111", a_in_ready, a_out_data);
    end
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (a_out_data !== 32'h22222222 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_emit1: data=%h ready=%b, want 22222222 1", a_out_data, a_in_ready);
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    n_tests++;
    if (a_out_data !== 32'h33333333 || a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_emit2: data=%h valid=%b, want 33333333 1", a_out_data, a_out_valid);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: valid=%b, want 0", a_out_valid);
    end
  endtask

  task automatic test_counter_sat();
    logic [1:0] exp_cnt;
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_mode   = 3'd5;
    b_in_off    = 3'd1;
    b_in_data   = 64'h0123456789ABCDEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_tests++;
      if (b_cnt !== exp_cnt || b_out_misalign !== 1'b1 || b_out_data !== 64'h0) begin
        n_fail++;
        $display("FAIL cnt_sat_%0d: cnt=%0d mis=%b data=%h, want %0d 1 0",
                 i, b_cnt, b_out_misalign, b_out_data, exp_cnt);
      end
    end
    b_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    b_cnt_clr  = 1'b0;
    b_in_valid = 1'b0;
    n_tests++;
    if (b_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL cnt_clr_prio: cnt=%0d, want 0", b_cnt);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    push_a(32'hAAAA5555, 2'd0, 3'd5);
    push_a(32'h12345678, 2'd1, 3'd5);
    n_tests++;
    if (a_in_ready !== 1'b0 || a_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL rst_mid_pre: ready=%b cnt=%0d, want 0 2", a_in_ready, a_cnt);
    end
    #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async: valid=%b data=%h cnt=%0d, want 0 0 0",
               a_out_valid, a_out_data, a_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_after: ready=%b valid=%b, want 1 0", a_in_ready, a_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_lb_lbu();
    test_lh_misalign();
    test_zext_lui_sext();
    test_backpressure();
    test_counter_sat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
